// File: rtl/store_trace_fifo.sv
// Store trace FIFO: captures CPU data-memory stores in an address window into a
// first-word-fall-through queue, drained via valid/ready, with a saturating drop counter.
module store_trace_fifo #(
  parameter int          DEPTH   = 16,
  parameter logic [31:0] ADDR_LO = 32'h0000_0000,
  parameter logic [31:0] ADDR_HI = 32'hFFFF_FFFF,
  parameter int          DCW     = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       memwrite,
  input  logic [31:0]                dataadr,
  input  logic [31:0]                writedata,
  input  logic                       clear,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [31:0]                m_addr,
  output logic [31:0]                m_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic [DCW-1:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0]  DEPTH_C  = CW'(DEPTH);
  localparam logic [DCW-1:0] DROP_MAX = {DCW{1'b1}};

  logic [31:0]    r_mem_addr [DEPTH];
  logic [31:0]    r_mem_data [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;
  logic           r_full;
  logic           r_overflow;
  logic [DCW-1:0] r_drop_cnt;

  logic [32:0]    w_diff_lo;
  logic [32:0]    w_diff_hi;
  logic           w_in_win;
  logic           w_push;
  logic           w_pop;
  logic           w_wr;
  logic           w_drop;
  logic [CW-1:0]  w_count_nxt;
  logic [DCW-1:0] w_drop_nxt;

  // Window test via 33-bit borrow so the compare stays unsigned and constant-free.
  assign w_diff_lo = {1'b0, dataadr} - {1'b0, ADDR_LO};
  assign w_diff_hi = {1'b0, ADDR_HI} - {1'b0, dataadr};
  assign w_in_win  = ~w_diff_lo[32] & ~w_diff_hi[32];

  assign w_push = memwrite & w_in_win;
  assign w_pop  = m_valid & m_ready;
  // A full FIFO still accepts a store when the head leaves in the same cycle.
  assign w_wr   = w_push & (~r_full | w_pop);
  assign w_drop = w_push & r_full & ~w_pop;

  // Next occupancy and saturating drop count.
  always_comb begin
    w_count_nxt = r_count;
    w_drop_nxt  = r_drop_cnt;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_wr) begin
      w_count_nxt = r_count - CW'(1);
    end else begin
      w_count_nxt = r_count;
    end
    if (w_drop && (r_drop_cnt != DROP_MAX)) begin
      w_drop_nxt = r_drop_cnt + DCW'(1);
    end else begin
      w_drop_nxt = r_drop_cnt;
    end
  end

  // Control state: pointers, occupancy, flags; clear outranks push and pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
      r_count    <= w_count_nxt;
      r_full     <= (w_count_nxt == DEPTH_C);
      r_drop_cnt <= w_drop_nxt;
    end
  end

  // Storage array, deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr && !clear && !reset) begin
      r_mem_addr[r_wr_ptr] <= dataadr;
      r_mem_data[r_wr_ptr] <= writedata;
    end
  end

  assign m_valid  = (r_count != '0);
  assign m_addr   = r_mem_addr[r_rd_ptr];
  assign m_data   = r_mem_data[r_rd_ptr];
  assign count    = r_count;
  assign full     = r_full;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule
